// File: rtl/axis_pix_pkg.sv
// Shared pixel formats, luma coefficients and sideband bundle for
// the RGB-to-luma stream path.
package axis_pix_pkg;

    localparam int PIX_W  = 24;
    localparam int CH_W   = 8;
    localparam int Y_W    = 8;
    localparam int PROD_W = 16;

    localparam int COEF_R = 77;
    localparam int COEF_G = 150;
    localparam int COEF_B = 29;
    localparam int ROUND  = 128;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } side_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb2y_mac.sv
// Three-stage luma datapath: products, rounded sum, then Y.
// Advances only when the shared pipeline enable is high.
module rgb2y_mac
    import axis_pix_pkg::*;
(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             en,
    input  logic [PIX_W-1:0] pix,
    output logic [Y_W-1:0]   y
);

    localparam logic [PROD_W-1:0] K_R   = PROD_W'(COEF_R);
    localparam logic [PROD_W-1:0] K_G   = PROD_W'(COEF_G);
    localparam logic [PROD_W-1:0] K_B   = PROD_W'(COEF_B);
    localparam logic [PROD_W-1:0] K_RND = PROD_W'(ROUND);

    logic [CH_W-1:0]   r;
    logic [CH_W-1:0]   g;
    logic [CH_W-1:0]   b;
    logic [PROD_W-1:0] p_r;
    logic [PROD_W-1:0] p_g;
    logic [PROD_W-1:0] p_b;
    logic [PROD_W-1:0] sum;

    assign r = pix[PIX_W-1 -: CH_W];
    assign g = pix[PIX_W-CH_W-1 -: CH_W];
    assign b = pix[CH_W-1:0];

    // Coefficients sum to 256, so the 16-bit sum never overflows.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            p_r <= '0;
            p_g <= '0;
            p_b <= '0;
            sum <= '0;
            y   <= '0;
        end else if (en) begin
            p_r <= K_R * PROD_W'(r);
            p_g <= K_G * PROD_W'(g);
            p_b <= K_B * PROD_W'(b);
            sum <= p_r + p_g + p_b + K_RND;
            y   <= Y_W'(sum >> (PROD_W - Y_W));
        end
    end

endmodule

// File: rtl/axis_rgb2y_conv.sv
// AXI-Stream RGB888 to 8-bit luma converter with frame/line tagging.
// One global enable stalls the whole 3-stage pipeline on backpressure.
module axis_rgb2y_conv
    import axis_pix_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [PIX_W-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [Y_W-1:0]   m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic             frame_done
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic          en;
    logic          hs;
    logic [2:0]    vld;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          col_wrap;
    logic          row_wrap;
    side_t         sd_in;
    side_t         sd1;
    side_t         sd2;
    side_t         sd3;

    assign en            = ~vld[2] | m_axis_tready;
    assign s_axis_tready = en;
    assign hs            = s_axis_tvalid & en;

    assign col_wrap = (col_cnt == COL_LAST);
    assign row_wrap = (row_cnt == ROW_LAST);

    assign sd_in = '{
        sof: (col_cnt == '0) && (row_cnt == '0),
        eol: col_wrap,
        eof: col_wrap && row_wrap
    };

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (hs) begin
            if (col_wrap) begin
                col_cnt <= '0;
                row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Bubbles travel with the data; sideband is zeroed on empty slots.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld <= '0;
            sd1 <= '0;
            sd2 <= '0;
            sd3 <= '0;
        end else if (en) begin
            vld <= {vld[1:0], s_axis_tvalid};
            sd1 <= s_axis_tvalid ? sd_in : '0;
            sd2 <= sd1;
            sd3 <= sd2;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= vld[2] & m_axis_tready & sd3.eof;
        end
    end

    rgb2y_mac u_mac (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en      (en),
        .pix     (s_axis_tdata),
        .y       (m_axis_tdata)
    );

    assign m_axis_tvalid = vld[2];
    assign m_axis_tuser  = sd3.sof;
    assign m_axis_tlast  = sd3.eol;

endmodule

// File: tb/tb_axis_rgb2y_conv.sv
// Scoreboard bench for axis_rgb2y_conv on a 4x2 frame.
// Directed pixels with hand-computed luma; monitor checks outputs.
module tb_axis_rgb2y_conv;

    localparam int W = 4;
    localparam int H = 2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [23:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tuser;
    logic        m_tlast;
    logic        frame_done;

    always #5 aclk = ~aclk;

    axis_rgb2y_conv #(.IMG_W(W), .IMG_H(H)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .frame_done    (frame_done)
    );

    typedef struct {
        logic [7:0] y;
        logic       sof;
        logic       eol;
        logic       eof;
        int         acc;
        bit         lat;
    } exp_t;

    // Hand-computed (77R+150G+29B+128)>>8
    logic [23:0] vp [10] = '{
        24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
        24'h808080, 24'h102030, 24'h123456, 24'h7F0000, 24'hC8643C
    };
    logic [7:0] vy [10] = '{
        8'd0, 8'd255, 8'd77, 8'd149, 8'd29,
        8'd128, 8'd29, 8'd46, 8'd38, 8'd126
    };

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  cur_y = '0;
    bit          lat_chk = 0;
    int          mcol = 0;
    int          mrow = 0;
    bit          exp_fd = 0;
    bit          fr_rec = 0;
    int          fr_n = 0;
    logic [15:0] u_bits = '0;
    logic [15:0] l_bits = '0;
    int          fd_cnt = 0;
    bit          tp_win = 0;
    int          tp_cnt = 0;
    bit          prev_stall = 0;
    logic [9:0]  held = '0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, between active edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                chk("s_tready", {31'b0, s_tready},
                    {31'b0, (!m_tvalid) || m_tready});
                if (prev_stall)
                    chk("hold", {22'b0, m_tuser, m_tlast, m_tdata},
                        {22'b0, held});
                prev_stall = m_tvalid && !m_tready;
                held = {m_tuser, m_tlast, m_tdata};
                if (frame_done || exp_fd)
                    chk("frame_done", {31'b0, frame_done},
                        {31'b0, exp_fd});
                if (frame_done && fr_rec) fd_cnt++;
                exp_fd = 0;
                if (m_tvalid && m_tready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious: got y=%0h expected none",
                                 m_tdata);
                    end else begin
                        e = q.pop_front();
                        chk("y", {24'b0, m_tdata}, {24'b0, e.y});
                        chk("tuser", {31'b0, m_tuser}, {31'b0, e.sof});
                        chk("tlast", {31'b0, m_tlast}, {31'b0, e.eol});
                        if (e.lat) chk("latency", cyc - e.acc, 3);
                        exp_fd = e.eof;
                        if (fr_rec && fr_n < 16) begin
                            u_bits[fr_n] = m_tuser;
                            l_bits[fr_n] = m_tlast;
                            fr_n++;
                        end
                        if (tp_win) tp_cnt++;
                    end
                end
                if (s_tvalid && s_tready) begin
                    e.y   = cur_y;
                    e.sof = (mcol == 0) && (mrow == 0);
                    e.eol = (mcol == W - 1);
                    e.eof = (mcol == W - 1) && (mrow == H - 1);
                    e.acc = cyc;
                    e.lat = lat_chk;
                    q.push_back(e);
                    if (mcol == W - 1) begin
                        mcol = 0;
                        mrow = (mrow == H - 1) ? 0 : mrow + 1;
                    end else begin
                        mcol++;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send(input int idx);
        bit done = 0;
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = vp[idx];
        cur_y    = vy[idx];
        while (!done) begin
            @(negedge aclk);
            done = s_tvalid && s_tready;
            @(posedge aclk);
            #1;
            n++;
            if (!done && n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no handshake expected one");
                done = 1;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            idle(1);
            n++;
        end
        idle(2);
        chk("drain", q.size(), 0);
    endtask

    // Called just after a rising edge; checks asynchronous clear.
    task automatic apply_reset();
        aresetn = 1'b0;
        #1;
        chk("rst_tvalid", {31'b0, m_tvalid}, 0);
        chk("rst_tuser", {31'b0, m_tuser}, 0);
        chk("rst_tlast", {31'b0, m_tlast}, 0);
        chk("rst_tdata", {24'b0, m_tdata}, 0);
        chk("rst_fd", {31'b0, frame_done}, 0);
        chk("rst_sready", {31'b0, s_tready}, 1);
        q.delete();
        mcol = 0;
        mrow = 0;
        exp_fd = 0;
        prev_stall = 0;
        idle(2);
        aresetn = 1'b1;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(1);
        apply_reset();

        lat_chk = 1;
        for (int i = 0; i < 10; i++) send(i);
        drain();

        idle(1);
        apply_reset();
        fr_rec = 1;
        for (int i = 0; i < 16; i++) send(i % 10);
        drain();
        fr_rec = 0;
        chk("frame_cnt", fr_n, 16);
        chk("frame_tuser", {16'b0, u_bits}, 32'h0101);
        chk("frame_tlast", {16'b0, l_bits}, 32'h8888);
        chk("frame_done_cnt", fd_cnt, 2);

        lat_chk = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) send(9 - (i % 10));
            end
            begin
                idle(4);
                m_tready = 1'b0;
                #1;
                chk("bp_sready", {31'b0, s_tready}, 0);
                idle(5);
                m_tready = 1'b1;
            end
        join
        drain();

        lat_chk = 1;
        for (int i = 0; i < 8; i++) begin
            send((i * 3) % 10);
            idle(1);
        end
        drain();

        lat_chk = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) send(i % 10);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    m_tready = ~m_tready;
                    if (k == 10) tp_win = 1;
                    if (k == 30) tp_win = 0;
                    idle(1);
                end
                m_tready = 1'b1;
            end
        join
        drain();
        chk("throughput", tp_cnt, 10);

        lat_chk = 1;
        for (int i = 0; i < 6; i++) send(i);
        apply_reset();
        for (int i = 0; i < 4; i++) send(i + 2);
        drain();

        chk("final_queue", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
